// File: rtl/scm_sess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scm_sess_ctrl
// Function : Measurement-session controller: arms, opens a packet/cycle
//            bounded window, enforces a guard drain, then reports done.
// Revision : 1.0 - initial release
// ============================================================================
module scm_sess_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MIN_GUARD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             md_mon_wr,
    output logic             sent_start,
    output logic             sent_end,
    output logic             stat_reset,
    output logic             sess_busy,
    output logic             sess_done,
    output logic [CNT_W-1:0] win_pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_min_guard = CNT_W'(MIN_GUARD);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_win_pkts;
    logic [CNT_W-1:0] r_win_cyc;
    logic [CNT_W-1:0] r_guard_cyc;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] w_cyc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cyc_inc;
    logic [CNT_W-1:0] w_guard_eff;
    logic             w_cfg_ok;
    logic             w_ctrl;
    logic             w_abort;
    logic             w_arm;
    logic             w_clr;
    logic             w_pkt_hit;
    logic             w_cyc_hit;
    logic             w_sent_end_nxt;
    logic             w_stat_rst_nxt;

    always_comb begin
        w_cfg_ok    = (r_state == S_IDLE) || (r_state == S_DONE);
        w_ctrl      = cfg_wr && (cfg_addr == 2'd0);
        w_abort     = w_ctrl && cfg_wdata[1];
        // Abort dominates arm; an arm with no window limit would never close.
        w_arm       = w_ctrl && cfg_wdata[0] && !cfg_wdata[1] && w_cfg_ok &&
                      ((r_win_pkts != '0) || (r_win_cyc != '0));
        w_clr       = w_ctrl && cfg_wdata[2] && w_cfg_ok;
        w_cnt_inc   = (&win_pkt_cnt) ? win_pkt_cnt : win_pkt_cnt + c_one;
        w_cyc_inc   = (&r_cyc) ? r_cyc : r_cyc + c_one;
        w_pkt_hit   = (r_win_pkts != '0) &&
                      ((md_mon_wr ? w_cnt_inc : win_pkt_cnt) >= r_win_pkts);
        w_cyc_hit   = (r_win_cyc != '0) && (w_cyc_inc >= r_win_cyc);
        w_guard_eff = (r_guard_cyc > c_min_guard) ? r_guard_cyc : c_min_guard;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = win_pkt_cnt;
        w_cyc_nxt      = r_cyc;
        w_sent_end_nxt = 1'b0;
        w_stat_rst_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_arm) begin
                    w_state_nxt    = S_ARM;
                    w_cnt_nxt      = '0;
                    w_stat_rst_nxt = 1'b1;
                end
                if (w_clr) begin
                    w_cnt_nxt      = '0;
                    w_stat_rst_nxt = 1'b1;
                end
            end
            S_ARM: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (md_mon_wr) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = c_one;
                    w_cyc_nxt   = '0;
                end
            end
            S_RUN: begin
                if (md_mon_wr) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                w_cyc_nxt = w_cyc_inc;
                if (w_abort) begin
                    w_state_nxt    = S_IDLE;
                    w_sent_end_nxt = 1'b1;
                end else if (w_pkt_hit || w_cyc_hit) begin
                    w_state_nxt    = S_DRAIN;
                    w_cyc_nxt      = '0;
                    w_sent_end_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                w_cyc_nxt = w_cyc_inc;
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cyc_inc >= w_guard_eff) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_win_pkts  <= '0;
            r_win_cyc   <= '0;
            r_guard_cyc <= '0;
            win_pkt_cnt <= '0;
            sent_start  <= 1'b0;
            sent_end    <= 1'b0;
            stat_reset  <= 1'b0;
            sess_busy   <= 1'b0;
            sess_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc       <= w_cyc_nxt;
            win_pkt_cnt <= w_cnt_nxt;
            sent_start  <= (w_state_nxt == S_RUN);
            sent_end    <= w_sent_end_nxt;
            stat_reset  <= w_stat_rst_nxt;
            sess_busy   <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN) ||
                           (w_state_nxt == S_DRAIN);
            sess_done   <= (w_state_nxt == S_DONE);
            if (cfg_wr && w_cfg_ok) begin
                case (cfg_addr)
                    2'd1:    r_win_pkts  <= cfg_wdata;
                    2'd2:    r_win_cyc   <= cfg_wdata;
                    2'd3:    r_guard_cyc <= cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scm_sess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scm_sess_ctrl
// Function : Directed self-checking bench for scm_sess_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scm_sess_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        md_mon_wr;
    logic        sent_start;
    logic        sent_end;
    logic        stat_reset;
    logic        sess_busy;
    logic        sess_done;
    logic [31:0] win_pkt_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_end = 0;
    int n_start = 0;
    int end_base;
    int start_base;

    scm_sess_ctrl #(.CNT_W(32), .MIN_GUARD(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .md_mon_wr   (md_mon_wr),
        .sent_start  (sent_start),
        .sent_end    (sent_end),
        .stat_reset  (stat_reset),
        .sess_busy   (sess_busy),
        .sess_done   (sess_done),
        .win_pkt_cnt (win_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-level occupancy of the window outputs
    always @(posedge clk) begin
        if (sent_end)   n_end   <= n_end + 1;
        if (sent_start) n_start <= n_start + 1;
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_wr    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic md_pulse();
        md_mon_wr = 1'b1;
        @(negedge clk);
        md_mon_wr = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k;
        k = 0;
        while (!sess_done && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk_val("wait_done", sess_done, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        md_mon_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk_val("rst_flags", {sent_start, sent_end, stat_reset, sess_busy, sess_done}, 0);
        chk_val("rst_cnt", win_pkt_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both windows zero: arm ignored
        cfg_write(2'd0, 32'h1);
        chk_val("arm0_busy", sess_busy, 0);
        chk_val("arm0_statrst", stat_reset, 0);

        // Packet-bounded window, guard 10, md every cycle for 7 cycles
        cfg_write(2'd1, 32'd5);
        cfg_write(2'd3, 32'd10);
        cfg_write(2'd0, 32'h1);
        chk_val("arm_statrst", stat_reset, 1);
        chk_val("arm_busy", sess_busy, 1);
        chk_val("arm_cnt", win_pkt_cnt, 0);
        end_base   = n_end;
        start_base = n_start;
        md_mon_wr = 1'b1;
        repeat (7) @(negedge clk);
        md_mon_wr = 1'b0;
        chk_val("pk_cnt", win_pkt_cnt, 5);
        chk_val("pk_nend", n_end - end_base, 1);
        chk_val("pk_nstart", n_start - start_base, 4);
        repeat (7) @(negedge clk);
        chk_val("pk_drain9_done", sess_done, 0);
        @(negedge clk);
        chk_val("pk_drain10_done", sess_done, 1);
        chk_val("pk_drain10_busy", sess_busy, 0);
        repeat (3) @(negedge clk);
        chk_val("done_hold_cnt", win_pkt_cnt, 5);

        // clr_stats in DONE
        cfg_write(2'd0, 32'h4);
        chk_val("clr_statrst", stat_reset, 1);
        chk_val("clr_cnt", win_pkt_cnt, 0);
        chk_val("clr_done", sess_done, 1);

        // Packets and cycles both 3, md every cycle
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd0, 32'h1);
        end_base = n_end;
        md_mon_wr = 1'b1;
        repeat (6) @(negedge clk);
        md_mon_wr = 1'b0;
        chk_val("both_cnt", win_pkt_cnt, 3);
        chk_val("both_nend", n_end - end_base, 1);
        wait_done(40);

        // Guard 1 -> min 4; WIN_PKTS write during RUN ignored
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd3, 32'd1);
        cfg_write(2'd0, 32'h1);
        md_pulse();
        cfg_write(2'd1, 32'd9);
        md_pulse();
        chk_val("g1_send", sent_end, 1);
        chk_val("g1_cnt", win_pkt_cnt, 2);
        repeat (3) @(negedge clk);
        chk_val("g1_drain3_done", sess_done, 0);
        @(negedge clk);
        chk_val("g1_drain4_done", sess_done, 1);

        // Cycle-bounded window of 20, sparse md
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'd20);
        cfg_write(2'd0, 32'h1);
        md_pulse();
        chk_val("cyc_entry_start", sent_start, 1);
        for (int i = 1; i <= 19; i++) begin
            md_mon_wr = (i % 3 == 0);
            @(negedge clk);
        end
        md_mon_wr = 1'b0;
        chk_val("cyc19_flags", {sent_start, sent_end}, 2'b10);
        @(negedge clk);
        chk_val("cyc20_flags", {sent_start, sent_end}, 2'b01);
        chk_val("cyc20_cnt", win_pkt_cnt, 7);
        wait_done(40);

        // Abort during RUN
        cfg_write(2'd0, 32'h1);
        md_pulse();
        end_base = n_end;
        cfg_write(2'd0, 32'h2);
        chk_val("abort_flags", {sent_start, sent_end, sess_busy, sess_done}, 4'b0100);
        @(negedge clk);
        chk_val("abort_send_once", sent_end, 0);
        chk_val("abort_nend", n_end - end_base, 1);

        // Arm and abort together in IDLE
        cfg_write(2'd0, 32'h3);
        chk_val("armabort", {sess_busy, stat_reset}, 2'b00);

        // Asynchronous reset mid-RUN
        cfg_write(2'd0, 32'h1);
        md_pulse();
        chk_val("prerst_start", sent_start, 1);
        end_base = n_end;
        rst_n = 1'b0;
        #1;
        chk_val("arst_flags", {sent_start, sent_end, stat_reset, sess_busy, sess_done}, 0);
        chk_val("arst_cnt", win_pkt_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_val("arst_nend", n_end - end_base, 0);
        cfg_write(2'd0, 32'h1);
        chk_val("arst_cfg_cleared", sess_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
